// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader streaming big-endian words into instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_wr_en,
    output logic [31:0] imem_wr_addr,
    output logic [31:0] imem_wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR} state_t;
`endif

    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

    state_t      state_q;
    logic        in_ready_q;
    logic        wr_en_q;
    logic [31:0] wr_addr_q;
    logic [31:0] wr_data_q;
    logic        cpu_hold_q;
    logic        done_q;
    logic        error_q;
    logic [7:0]  len_hi_q;
    logic [15:0] len_q;
    logic [15:0] word_idx_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] asm_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  xor_q;
`endif

    logic        accept;
    logic [15:0] len_d;
    logic [31:0] asm_d;

    assign accept = in_valid & in_ready_q;
    assign len_d  = {len_hi_q, in_data};
    assign asm_d  = {asm_q, in_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 32'd0;
            wr_data_q  <= 32'd0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            len_hi_q   <= 8'd0;
            len_q      <= 16'd0;
            word_idx_q <= 16'd0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= 8'd0;
`endif
        end else begin
            wr_en_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (accept) xor_q <= xor_q ^ in_data;
`endif
            case (state_q)
                S_IDLE: begin
                    state_q    <= S_LEN_HI;
                    in_ready_q <= 1'b1;
                end
                S_LEN_HI: if (accept) begin
                    len_hi_q <= in_data;
                    state_q  <= S_LEN_LO;
                end
                S_LEN_LO: if (accept) begin
                    len_q      <= len_d;
                    word_idx_q <= 16'd0;
                    byte_cnt_q <= 2'd0;
                    if ({1'b0, len_d} > DEPTH_L) begin
                        state_q    <= S_ERR;
                        in_ready_q <= 1'b0;
                        error_q    <= 1'b1;
                    end else if (len_d == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q    <= S_CHK;
`else
                        state_q    <= S_DONE;
                        in_ready_q <= 1'b0;
`endif
                    end else begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: if (accept) begin
                    asm_q      <= asm_d[23:0];
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_q    <= 1'b1;
                        wr_data_q  <= asm_d;
                        wr_addr_q  <= {14'd0, word_idx_q, 2'b00};
                        word_idx_q <= word_idx_q + 16'd1;
                        if (word_idx_q == len_q - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_q    <= S_CHK;
`else
                            state_q    <= S_DONE;
                            in_ready_q <= 1'b0;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: if (accept) begin
                    in_ready_q <= 1'b0;
                    if (in_data == xor_q) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                    end else begin
                        state_q <= S_ERR;
                        error_q <= 1'b1;
                    end
                end
`endif
                // done is raised one cycle after entry so the last write lands first
                S_DONE: begin
                    done_q     <= 1'b1;
                    cpu_hold_q <= 1'b0;
                end
                S_ERR: ;
                default: begin
                    state_q    <= S_ERR;
                    in_ready_q <= 1'b0;
                    error_q    <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_wr_en   = wr_en_q;
    assign imem_wr_addr = wr_addr_q;
    assign imem_wr_data = wr_data_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader.
// Honours IMEM_LOADER_CHECKSUM_EN when the design is built with it.
module tb_imem_loader;

    localparam int DEPTH = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        imem_wr_en;
    logic [31:0] imem_wr_addr;
    logic [31:0] imem_wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    imem_loader #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr),
        .imem_wr_data(imem_wr_data), .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          t;
    } wr_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rel = 0;
    int t_ready, t_done, t_hold, t_err;
    int accepted;
    wr_t wr_q[$];
    wr_t exp_wr[$];
    logic [7:0] img[$];
    bit exp_done, exp_err;
    int exp_acc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (imem_wr_en) wr_q.push_back('{imem_wr_addr, imem_wr_data, cyc - rel});
            if (in_ready && t_ready < 0) t_ready = cyc - rel;
            if (done && t_done < 0) t_done = cyc - rel;
            if (!cpu_hold && t_hold < 0) t_hold = cyc - rel;
            if (error && t_err < 0) t_err = cyc - rel;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input bit check_vals);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        if (check_vals) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_wr_en", imem_wr_en, 0);
            check("rst_wr_addr", imem_wr_addr, 0);
            check("rst_wr_data", imem_wr_data, 0);
            check("rst_cpu_hold", cpu_hold, 1);
            check("rst_done", done, 0);
            check("rst_error", error, 0);
        end
        wr_q.delete();
        t_ready = -1; t_done = -1; t_hold = -1; t_err = -1;
        rel = cyc;
        reset = 1'b1;
    endtask

    // mode 0: valid always, 1: valid every other cycle, 2: random valid
    task automatic send(input int mode, input int budget);
        int idx = 0;
        int n = 0;
        bit hs = 1'b0;
        bit v;
        while (n < budget) begin
            @(negedge clk);
            if (hs) idx++;
            if (idx >= img.size() || error) break;
            case (mode)
                0: v = 1'b1;
                1: v = (n % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            in_valid = v;
            in_data = v ? img[idx] : 8'($urandom);
            hs = v && in_ready;
            n++;
        end
        in_valid = 1'b0;
        accepted = idx;
    endtask

    task automatic build_image(input int n, input bit bad_chk);
        logic [7:0] x = 8'd0;
        img.delete();
        img.push_back(8'(n >> 8));
        img.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
        foreach (img[i]) x ^= img[i];
        if (CHK_EN) img.push_back(bad_chk ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
    endtask

    task automatic model();
        int n;
        logic [7:0] x;
        exp_wr.delete();
        exp_done = 1'b0;
        exp_err = 1'b0;
        n = int'(img[0]) * 256 + int'(img[1]);
        if (n > DEPTH) begin
            exp_err = 1'b1;
            exp_acc = 2;
            return;
        end
        for (int i = 0; i < n; i++)
            exp_wr.push_back('{32'(4 * i),
                {img[2 + 4 * i], img[3 + 4 * i], img[4 + 4 * i], img[5 + 4 * i]}, 0});
        exp_acc = img.size();
        if (CHK_EN) begin
            x = 8'd0;
            for (int j = 0; j < 2 + 4 * n; j++) x ^= img[j];
            if (img[2 + 4 * n] == x) exp_done = 1'b1;
            else exp_err = 1'b1;
        end else begin
            exp_done = 1'b1;
        end
    endtask

    task automatic verify(input string tag);
        int m;
        model();
        repeat (3) @(negedge clk);
        check({tag, "_accepted"}, accepted, exp_acc);
        check({tag, "_n_writes"}, wr_q.size(), exp_wr.size());
        m = (wr_q.size() < exp_wr.size()) ? wr_q.size() : exp_wr.size();
        for (int i = 0; i < m; i++) begin
            check({tag, "_addr"}, wr_q[i].addr, exp_wr[i].addr);
            check({tag, "_data"}, wr_q[i].data, exp_wr[i].data);
        end
        check({tag, "_done"}, done, exp_done);
        check({tag, "_error"}, error, exp_err);
        check({tag, "_cpu_hold"}, cpu_hold, !exp_done);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    task automatic load_fixed(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        img.delete();
        img.push_back(b0); img.push_back(b1); img.push_back(b2);
        img.push_back(b3); img.push_back(b4); img.push_back(b5);
    endtask

    initial begin
        logic [31:0] s_addr, s_data;
        int nwr, len;

        // Reference image: two words, back-to-back bytes
        do_reset(1'b1);
        load_fixed(8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05);
        img.push_back(8'hAC); img.push_back(8'h09); img.push_back(8'h00); img.push_back(8'h00);
        if (CHK_EN) img.push_back(8'h00 ^ 8'h02 ^ 8'h20 ^ 8'h08 ^ 8'h05 ^ 8'hAC ^ 8'h09);
        send(0, 40);
        verify("streamA");
        check("streamA_ready_rise", t_ready, 1);
        check("streamA_data0", (wr_q.size() > 0) ? wr_q[0].data : 32'hx, 32'h20080005);
        check("streamA_strobe0_cyc", (wr_q.size() > 0) ? wr_q[0].t : -1, 7);
        check("streamA_strobe1_cyc", (wr_q.size() > 1) ? wr_q[1].t : -1, 11);
        check("streamA_done_cyc", t_done, 12);
        check("streamA_hold_fall_cyc", t_hold, 12);

        // Traffic after done is never accepted and disturbs nothing
        s_addr = imem_wr_addr;
        s_data = imem_wr_data;
        nwr = wr_q.size();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data = 8'($urandom);
            @(negedge clk);
            check("post_done_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        check("post_done_strobes", wr_q.size(), nwr);
        check("post_done_addr", imem_wr_addr, s_addr);
        check("post_done_data", imem_wr_data, s_data);
        check("post_done_done", done, 1);
        check("post_done_hold", cpu_hold, 0);

        // Same image with in_valid toggling
        do_reset(1'b0);
        load_fixed(8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05);
        img.push_back(8'hAC); img.push_back(8'h09); img.push_back(8'h00); img.push_back(8'h00);
        if (CHK_EN) img.push_back(8'h00 ^ 8'h02 ^ 8'h20 ^ 8'h08 ^ 8'h05 ^ 8'hAC ^ 8'h09);
        send(1, 80);
        verify("toggle");
        check("toggle_spacing", (wr_q.size() > 1) ? wr_q[1].t - wr_q[0].t : -1, 8);

        // Length one past capacity
        do_reset(1'b0);
        load_fixed(8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44);
        send(0, 40);
        verify("len_over");
        check("len_over_err_cyc", t_err, 3);

        // Reset after two data bytes, then a fresh image
        do_reset(1'b0);
        img.delete();
        img.push_back(8'h00); img.push_back(8'h01); img.push_back(8'hAA); img.push_back(8'hBB);
        send(0, 20);
        check("partial_no_strobe", wr_q.size(), 0);
        check("partial_hold", cpu_hold, 1);
        do_reset(1'b0);
        load_fixed(8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44);
        if (CHK_EN) img.push_back(8'h01 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
        send(0, 40);
        verify("after_reset");
        check("after_reset_word", (wr_q.size() > 0) ? wr_q[0].data : 32'hx, 32'h11223344);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset(1'b0);
        load_fixed(8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78);
        img.push_back(8'h09);
        send(0, 40);
        verify("chk_good");
        check("chk_good_done", done, 1);
        do_reset(1'b0);
        load_fixed(8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78);
        img.push_back(8'h08);
        send(0, 40);
        verify("chk_bad");
        check("chk_bad_error", error, 1);
        check("chk_bad_hold", cpu_hold, 1);
`endif

        // Empty image and an image filling memory exactly
        do_reset(1'b0);
        build_image(0, 1'b0);
        send(0, 20);
        verify("len_zero");
        do_reset(1'b0);
        build_image(DEPTH, 1'b0);
        send(0, 4 * DEPTH + 40);
        verify("len_full");

        for (int it = 0; it < 12; it++) begin
            do_reset(1'b0);
            len = $urandom_range(1, 6);
            build_image(len, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 9) == 0) begin
                len = $urandom_range(DEPTH + 1, 65535);
                img[0] = 8'(len >> 8);
                img[1] = 8'(len);
            end
            send($urandom_range(0, 2), img.size() * 4 + 40);
            verify("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
